// File: rtl/alu16_pkg.sv
// rtl/alu16_pkg.sv - shared types and constants for the 16-bit ALU sequencer
//
// Holds the ALU opcode encoding (identical to the 8-bit ALU SEL encoding),
// the sequencer state type, the carry-in source selector and a helper that
// resolves a carry-in source to a bit.
package alu16_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDC = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBC = 4'd3,
    ALU_CMP  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_TEST = 4'd8,
    ALU_LSL  = 4'd9,
    ALU_LSR  = 4'd10,
    ALU_ROL  = 4'd11,
    ALU_ROR  = 4'd12,
    ALU_ASR  = 4'd13,
    ALU_MOV  = 4'd14,
    ALU_NOP  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef enum logic [2:0] {
    CIN_ZERO = 3'd0,
    CIN_REQ  = 3'd1,
    CIN_C1   = 3'd2,
    CIN_A15  = 3'd3,
    CIN_A0   = 3'd4
  } cin_src_e;

  // SEL value that parks the ALU whenever no pass is in flight.
  localparam logic [3:0] ALU_SEL_IDLE = 4'd15;

  function automatic logic cin_pick(input cin_src_e src, input logic req_cin,
                                    input logic c1, input logic a15, input logic a0);
    logic v;
    v = 1'b0;
    case (src)
      CIN_REQ: v = req_cin;
      CIN_C1:  v = c1;
      CIN_A15: v = a15;
      CIN_A0:  v = a0;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu16_op_decode.sv
// rtl/alu16_op_decode.sv - maps a 16-bit opcode onto two 8-bit ALU passes
//
// Ports:
//   op        in  4  requested operation (ALU SEL encoding)
//   sel1      out 4  ALU SEL for the first pass
//   sel2      out 4  ALU SEL for the second pass
//   hi_first  out 1  1: first pass works on the high byte (right shifts)
//   cin1_src  out    carry-in source for the first pass
//   cin2_src  out    carry-in source for the second pass
//   we        out 1  write-back enable for the response
module alu16_op_decode
  import alu16_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] sel1,
  output logic [3:0] sel2,
  output logic       hi_first,
  output cin_src_e   cin1_src,
  output cin_src_e   cin2_src,
  output logic       we
);

  always_comb begin
    sel1     = op;
    sel2     = op;
    hi_first = 1'b0;
    cin1_src = CIN_ZERO;
    cin2_src = CIN_C1;
    we       = 1'b1;
    case (alu_op_e'(op))
      ALU_ADD: begin
        sel1 = ALU_ADD;
        sel2 = ALU_ADDC;
      end
      ALU_ADDC: begin
        cin1_src = CIN_REQ;
      end
      ALU_SUB, ALU_CMP: begin
        // CMP runs exactly like SUB; only write-back differs.
        sel1 = ALU_SUB;
        sel2 = ALU_SUBC;
      end
      ALU_SUBC: begin
        cin1_src = CIN_REQ;
      end
      ALU_AND, ALU_OR, ALU_XOR, ALU_TEST: begin
        cin2_src = CIN_ZERO;
      end
      ALU_LSL: begin
        cin1_src = CIN_REQ;
      end
      ALU_ROL: begin
        // Rotate is an LSL chain with the top bit wrapped into bit 0.
        sel1     = ALU_LSL;
        sel2     = ALU_LSL;
        cin1_src = CIN_A15;
      end
      ALU_LSR: begin
        hi_first = 1'b1;
        cin1_src = CIN_REQ;
      end
      ALU_ROR: begin
        sel1     = ALU_LSR;
        sel2     = ALU_LSR;
        hi_first = 1'b1;
        cin1_src = CIN_A0;
      end
      ALU_ASR: begin
        // Sign replication only matters for the high byte; the low byte
        // is a plain LSR fed by the bit shifted out of the high byte.
        sel1     = ALU_ASR;
        sel2     = ALU_LSR;
        hi_first = 1'b1;
      end
      ALU_MOV: begin
        cin1_src = CIN_REQ;
        cin2_src = CIN_REQ;
      end
      ALU_NOP: begin
        cin2_src = CIN_ZERO;
      end
      default: begin
      end
    endcase
    if (op == ALU_CMP || op == ALU_TEST || op == ALU_NOP) begin
      we = 1'b0;
    end
  end

endmodule

// File: rtl/alu16_sequencer.sv
// rtl/alu16_sequencer.sv - runs 16-bit operations as two chained 8-bit ALU passes
//
// Optional feature macro: ALU16_CARRY_REG_EN (internal carry flag register
// replaces req_cin as the carry source).
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         request handshake
//   req_op/req_a/req_b/req_cin  request payload, latched at acceptance
//   rsp_valid/rsp_ready         response handshake
//   rsp_result/rsp_c/rsp_z/rsp_we  registered response payload
//   alu_sel/alu_a/alu_b/alu_cin    drive the external combinational 8-bit ALU
//   alu_result/alu_c/alu_z         ALU outputs, sampled the cycle they are driven
module alu16_sequencer
  import alu16_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [DW-1:0]   req_a,
  input  logic [DW-1:0]   req_b,
  input  logic            req_cin,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_result,
  output logic            rsp_c,
  output logic            rsp_z,
  output logic            rsp_we,
  output logic [OP_W-1:0] alu_sel,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic            alu_cin,
  input  logic [7:0]      alu_result,
  input  logic            alu_c,
  input  logic            alu_z
);

  localparam int BW = DW / 2;

  if (DW != 16 || OP_W != 4) begin : g_param_check
    $error("alu16_sequencer: DW must be 16 and OP_W must be 4");
  end

  seq_state_e      state, next_state;
  logic [OP_W-1:0] op_q;
  logic [DW-1:0]   a_q, b_q;
  logic            cin_q;
  logic [7:0]      r1_q;
  logic            c1_q, z1_q;
  logic            cin_eff;
  logic            is_nop;

  logic [3:0] sel1, sel2;
  logic       hi_first;
  cin_src_e   cin1_src, cin2_src;
  logic       dec_we;

  alu16_op_decode u_decode (
    .op       (op_q),
    .sel1     (sel1),
    .sel2     (sel2),
    .hi_first (hi_first),
    .cin1_src (cin1_src),
    .cin2_src (cin2_src),
    .we       (dec_we)
  );

  assign is_nop = (op_q == ALU_SEL_IDLE);

`ifdef ALU16_CARRY_REG_EN
  logic c_flag;
  logic unused_req_cin;
  assign unused_req_cin = cin_q;
  assign cin_eff        = c_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_flag <= 1'b0;
    end else if (state == DONE && rsp_ready) begin
      c_flag <= rsp_c;
    end
  end
`else
  assign cin_eff = cin_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_sel    = ALU_SEL_IDLE;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = PASS1;
        end
      end
      PASS1: begin
        next_state = PASS2;
        if (!is_nop) begin
          alu_sel = sel1;
          alu_a   = hi_first ? a_q[DW-1:BW] : a_q[BW-1:0];
          alu_b   = hi_first ? b_q[DW-1:BW] : b_q[BW-1:0];
          alu_cin = cin_pick(cin1_src, cin_eff, c1_q, a_q[DW-1], a_q[0]);
        end
      end
      PASS2: begin
        next_state = DONE;
        if (!is_nop) begin
          alu_sel = sel2;
          alu_a   = hi_first ? a_q[BW-1:0] : a_q[DW-1:BW];
          alu_b   = hi_first ? b_q[BW-1:0] : b_q[DW-1:BW];
          alu_cin = cin_pick(cin2_src, cin_eff, c1_q, a_q[DW-1], a_q[0]);
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= ALU_SEL_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      r1_q       <= '0;
      c1_q       <= 1'b0;
      z1_q       <= 1'b0;
      rsp_result <= '0;
      rsp_c      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_we     <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_q  <= req_op;
        a_q   <= req_a;
        b_q   <= req_b;
        cin_q <= req_cin;
      end
      if (state == PASS1) begin
        r1_q <= alu_result;
        c1_q <= alu_c;
        z1_q <= alu_z;
      end
      // Response is only written at the end of PASS2, so it holds steady
      // for the whole DONE state however long the consumer stalls.
      if (state == PASS2) begin
        if (is_nop) begin
          rsp_result <= '0;
          rsp_c      <= 1'b0;
          rsp_z      <= 1'b1;
          rsp_we     <= 1'b0;
        end else begin
          rsp_result <= hi_first ? {r1_q, alu_result} : {alu_result, r1_q};
          rsp_c      <= alu_c;
          rsp_z      <= z1_q & alu_z;
          rsp_we     <= dec_we;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// tb/tb_alu16_sequencer.sv - scoreboard bench for alu16_sequencer with a behavioural 8-bit ALU
module tb_alu16_sequencer;
  import alu16_pkg::*;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        z;
    logic        we;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_c;
  logic        rsp_z;
  logic        rsp_we;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [7:0]  alu_result;
  logic        alu_c;
  logic        alu_z;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];
  logic tb_cflag;

  alu16_sequencer #(.OP_W(4), .DW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_c      (rsp_c),
    .rsp_z      (rsp_z),
    .rsp_we     (rsp_we),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_c      (alu_c),
    .alu_z      (alu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-bit ALU
  always_comb begin
    logic [8:0] t;
    t = '0;
    case (alu_sel)
      4'd0:       t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1:       t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      4'd2, 4'd4: t = {1'b0, alu_a} - {1'b0, alu_b};
      4'd3:       t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
      4'd5, 4'd8: t = {1'b0, alu_a & alu_b};
      4'd6:       t = {1'b0, alu_a | alu_b};
      4'd7:       t = {1'b0, alu_a ^ alu_b};
      4'd9:       t = {alu_a[7], alu_a[6:0], alu_cin};
      4'd10:      t = {alu_a[0], alu_cin, alu_a[7:1]};
      4'd11:      t = {alu_a[7], alu_a[6:0], alu_a[7]};
      4'd12:      t = {alu_a[0], alu_a[0], alu_a[7:1]};
      4'd13:      t = {alu_a[0], alu_a[7], alu_a[7:1]};
      4'd14:      t = {alu_cin, alu_b};
      default:    t = '0;
    endcase
    alu_result = t[7:0];
    alu_c      = t[8];
    alu_z      = (t[7:0] == 8'd0);
  end

  // 16-bit reference written directly from the operation semantics
  function automatic exp_t ref16(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin);
    logic [16:0] t;
    exp_t e;
    t = '0;
    case (op)
      4'd0:       t = {1'b0, a} + {1'b0, b};
      4'd1:       t = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      4'd2, 4'd4: t = {1'b0, a} - {1'b0, b};
      4'd3:       t = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      4'd5, 4'd8: t = {1'b0, a & b};
      4'd6:       t = {1'b0, a | b};
      4'd7:       t = {1'b0, a ^ b};
      4'd9:       t = {a[15], a[14:0], cin};
      4'd10:      t = {a[0], cin, a[15:1]};
      4'd11:      t = {a[15], a[14:0], a[15]};
      4'd12:      t = {a[0], a[0], a[15:1]};
      4'd13:      t = {a[0], a[15], a[15:1]};
      4'd14:      t = {cin, b};
      default:    t = '0;
    endcase
    e.r  = t[15:0];
    e.c  = t[16];
    e.z  = (t[15:0] == 16'd0);
    e.we = !(op == 4'd4 || op == 4'd8 || op == 4'd15);
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("rsp_result", {16'd0, rsp_result}, {16'd0, e.r});
          check_eq("rsp_c", {31'd0, rsp_c}, {31'd0, e.c});
          check_eq("rsp_z", {31'd0, rsp_z}, {31'd0, e.z});
          check_eq("rsp_we", {31'd0, rsp_we}, {31'd0, e.we});
        end
      end
    end
  endtask

  function automatic logic model_cin(input logic cin);
`ifdef ALU16_CARRY_REG_EN
    return tb_cflag;
`else
    return cin;
`endif
  endfunction

  task automatic push_exp(input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic cin);
    exp_t e;
    e = ref16(op, a, b, model_cin(cin));
    sb.push_back(e);
    tb_cflag = e.c;
  endtask

  // Returns #1 after the accepting edge, i.e. with the DUT in PASS1.
  task automatic send(input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic cin);
    int n;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    push_exp(op, a, b, cin);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", {31'd0, (sb.size() != 0)}, 32'd0);
  endtask

  task automatic wait_rsp_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    logic seen;
    n_tests   = 0;
    n_fail    = 0;
    tb_cflag  = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    rsp_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
    check_eq("rst_rsp_flags", {29'd0, rsp_c, rsp_z, rsp_we}, 32'd0);
    check_eq("rst_alu_sel", {28'd0, alu_sel}, 32'd15);
    check_eq("rst_alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
    check_eq("rst_alu_cin", {31'd0, alu_cin}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADD with inter-byte carry, pass sequence and latency
    send(4'd0, 16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    check_eq("add_p1_sel", {28'd0, alu_sel}, 32'd0);
    check_eq("add_p1_ab", {16'd0, alu_a, alu_b}, 32'h0000FF01);
    check_eq("add_p1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check_eq("add_p2_sel", {28'd0, alu_sel}, 32'd1);
    check_eq("add_p2_cin", {31'd0, alu_cin}, 32'd1);
    check_eq("add_p2_a", {24'd0, alu_a}, 32'h00);
    check_eq("add_p2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check_eq("add_rsp_valid_k2", {31'd0, rsp_valid}, 32'd1);

    send(4'd2, 16'h0000, 16'h0001, 1'b0);
    send(4'd4, 16'h1234, 16'h1234, 1'b0);

    // Shifts; right shifts must issue the high byte first
    send(4'd10, 16'h0101, 16'h0000, 1'b1);
    @(negedge clk);
    check_eq("lsr_p1_sel", {28'd0, alu_sel}, 32'd10);
    check_eq("lsr_p1_cin", {31'd0, alu_cin}, 32'd1);
    send(4'd10, 16'hAB01, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("lsr_hi_first", {24'd0, alu_a}, 32'hAB);
    send(4'd12, 16'h0001, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("ror_p1_a", {24'd0, alu_a}, 32'h00);
    check_eq("ror_p1_cin", {31'd0, alu_cin}, 32'd1);
    @(negedge clk);
    check_eq("ror_p2_a", {24'd0, alu_a}, 32'h01);
    send(4'd13, 16'h8001, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("asr_p1_sel", {28'd0, alu_sel}, 32'd13);
    check_eq("asr_p1_a", {24'd0, alu_a}, 32'h80);
    @(negedge clk);
    check_eq("asr_p2_sel", {28'd0, alu_sel}, 32'd10);
    send(4'd11, 16'h8000, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("rol_p1_a", {24'd0, alu_a}, 32'h00);
    check_eq("rol_p1_cin", {31'd0, alu_cin}, 32'd1);

    // Op 15: no ALU passes
    send(4'd15, 16'h1234, 16'h5678, 1'b1);
    @(negedge clk);
    check_eq("nop_p1_sel", {28'd0, alu_sel}, 32'd15);
    @(negedge clk);
    check_eq("nop_p2_sel", {28'd0, alu_sel}, 32'd15);
    drain();

    // Backpressure with a second request waiting
    rsp_ready = 1'b0;
    send(4'd7, 16'h5AA5, 16'h0FF0, 1'b0);
    req_valid = 1'b1;
    req_op    = 4'd6;
    req_a     = 16'h1200;
    req_b     = 16'h0034;
    req_cin   = 1'b0;
    wait_rsp_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp_rsp_result", {16'd0, rsp_result}, 32'h5555);
      check_eq("bp_rsp_flags", {29'd0, rsp_c, rsp_z, rsp_we}, 32'b001);
      check_eq("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_no_early_accept", {31'd0, req_ready}, 32'd0);
    push_exp(4'd6, 16'h1200, 16'h0034, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("bp_ready_after_hs", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_second_pass1", {28'd0, alu_sel}, 32'd6);
    drain();

    // Reset during PASS2
    send(4'd0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("midrst_alu_sel", {28'd0, alu_sel}, 32'd15);
    sb.delete();
    tb_cflag = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check_eq("midrst_no_rsp", {31'd0, seen}, 32'd0);

    // Carry chaining across operations
    send(4'd0, 16'hFFFF, 16'h0001, 1'b0);
    send(4'd1, 16'h0000, 16'h0000, 1'b0);
    drain();

    // Random operations
    for (int i = 0; i < 24; i++) begin
      send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
